fa16_rev_seq: RTL and testbench
===============================

Name: fa16_rev_seq

Overview:
- Clocked sequencer and round-trip checker that drives the bidirectional reversible 16-bit adder wrapper (fa16_rev) from its host side.
- Accepts an add request and runs the forward pass (dir=0), capturing S/A_B/C0_b/C15.
- Then runs the backward (uncompute) pass (dir=1), re-driving the captured outputs into the r_ port.
- Compares the recovered A/B/C0_f/Z to the originals, checks S against a golden sum, and returns the result with error flags.

Parameters:
W, 16, datapath width; must match the adder.
SETTLE_CYC, 2, cycles each pass holds dir and drive stable before sampling; legal range 1..15.
ERRCNT_W, 8, width of the saturating error counter.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request valid
req_ready  out  1  high only in IDLE
req_a  in  W  operand A
req_b  in  W  operand B
req_c0  in  1  carry-in
req_z  in  1  ancilla Z
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_s  out  W  captured forward sum
rsp_c15  out  1  captured carry-out
rsp_err  out  2  bit0 = reverse mismatch, bit1 = sum mismatch
err_cnt  out  ERRCNT_W  saturating count of responses with rsp_err!=0
dir  out  1  0 = forward, 1 = backward, to fa16_rev
f_a, f_b  out  W  forward operands
f_c0_f, f_z  out  1  forward carry/ancilla
f_s, f_a_b  in  W  forward results
f_c0_b, f_c15  in  1  forward results
r_s, r_a_b  out  W  backward drive (captured values)
r_c0_b, r_c15  out  1  backward drive
r_a, r_b  in  W  recovered operands
r_c0_f, r_z  in  1  recovered carry/ancilla

Behaviour:
- Clocking: one clock (clk). Reset is synchronous and active-high (rst). All outputs are registered.
- Reset values: state=IDLE, dir=0, all f_*/r_* drives=0, rsp_*=0, rsp_valid=0, req_ready=1, err_cnt=0, settle counter=0.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: latch operands into op regs, drive f_* from them, dir=0, counter=0, go to FWD.
- FWD:
  - Stays SETTLE_CYC cycles, dir=0.
  - On the last cycle, capture f_s, f_a_b, f_c0_b, f_c15 into cap regs and compute sum_mismatch.
  - Next: REV with dir=1 and r_* driven from cap regs on that same edge. f_* hold their values (the wrapper tristates by dir).
- REV:
  - Stays SETTLE_CYC cycles, dir=1.
  - On the last cycle, compare {r_a,r_b,r_c0_f,r_z} with op regs; any difference sets rev_mismatch.
  - Next: RSP, dir=0, r_* return to 0.
- RSP:
  - rsp_valid=1; rsp_s/rsp_c15/rsp_err are held stable until rsp_ready.
  - On rsp_valid&&rsp_ready: go to IDLE. err_cnt increments if rsp_err!=0, saturating at all-ones.
- Latency: acceptance at edge T; FWD occupies cycles T+1..T+S; REV occupies T+S+1..T+2S; rsp_valid is high from T+2S+1. With default S=2 that is 5 cycles.
- Golden sum: {c,s} = req_a + req_b + req_c0 at W+1 bits, compared with {f_c15,f_s}.
  - Checked only when req_z==0; sum_mismatch=0 when req_z==1.
- Throughput: one request per 2S+2 cycles minimum. No request is accepted outside IDLE.
- Reset in any state: abort immediately to reset values. No response for the aborted request; err_cnt clears.
- req_valid outside IDLE is ignored (no latching).
- Back-to-back: rsp_ready in RSP and req_valid on the following IDLE cycle are both legal. No bypass: IDLE always lasts at least 1 cycle.

Decomposition:
- Package fa16_rev_seq_pkg:
  - state enum {IDLE, FWD, REV, RSP}
  - W default
  - CNT_W=4 for the settle counter
  - ERR_REV=0 and ERR_SUM=1 bit indices
- Sub-module fa16_rev_chk (combinational):
  - Inputs: op regs, cap regs, r_* inputs.
  - Outputs: rev_mismatch and sum_mismatch.
  - Computes the golden add and equality compares.
  - FSM, counters and registers remain in fa16_rev_seq.

Test Plan:
- a=0x1234, b=0x0FED, c0=0, z=0, core model correct -> rsp_s=0x2221, rsp_c15=0, rsp_err=0; rsp_valid exactly 5 cycles after acceptance; dir=0 for 2 cycles then 1 for 2 cycles.
- a=0xFFFF, b=0x0001, c0=1, z=0 -> rsp_s=0x0001, rsp_c15=1, rsp_err=0; r_s=0x0001, r_c15=1 observed during REV.
- Core model flips r_a[3] during the backward pass -> rsp_err=2'b01, err_cnt=1 after handshake. Forward returns s off by 1 -> rsp_err=2'b10, err_cnt=2.
- rsp_ready held low for 10 cycles -> rsp_* stable, req_ready=0, and a req_valid pulse in that window is not latched. rsp_ready=1 -> IDLE next cycle, req_ready=1.
- rst asserted during the first REV cycle -> next cycle state IDLE, dir=0, r_*=0, rsp_valid stays 0, err_cnt=0. A new request then completes normally.
- 300 injected-error requests -> err_cnt saturates at 0xFF and does not wrap.

Source files
------------

// File: rtl/fa16_rev_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fa16_rev_seq_pkg                                                     |
// | Shared types and constants for the fa16_rev round-trip sequencer.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package fa16_rev_seq_pkg;

    localparam int c_W       = 16;
    localparam int c_CNT_W   = 4;
    localparam int c_ERR_REV = 0;
    localparam int c_ERR_SUM = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_REV  = 2'd2,
        ST_RSP  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fa16_rev_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fa16_rev_seq_if / fa16_rev_core_if                                   |
// | Host request/response bus and the adder-core drive/observe bus.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface fa16_rev_seq_if #(
    parameter int W        = 16,
    parameter int ERRCNT_W = 8
);
    logic                req_valid;
    logic                req_ready;
    logic [W-1:0]        req_a;
    logic [W-1:0]        req_b;
    logic                req_c0;
    logic                req_z;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [W-1:0]        rsp_s;
    logic                rsp_c15;
    logic [1:0]          rsp_err;
    logic [ERRCNT_W-1:0] err_cnt;

    modport master (
        output req_valid, req_a, req_b, req_c0, req_z, rsp_ready,
        input  req_ready, rsp_valid, rsp_s, rsp_c15, rsp_err, err_cnt
    );

    modport slave (
        input  req_valid, req_a, req_b, req_c0, req_z, rsp_ready,
        output req_ready, rsp_valid, rsp_s, rsp_c15, rsp_err, err_cnt
    );
endinterface

interface fa16_rev_core_if #(
    parameter int W = 16
);
    logic         dir;
    logic [W-1:0] f_a;
    logic [W-1:0] f_b;
    logic         f_c0_f;
    logic         f_z;
    logic [W-1:0] f_s;
    logic [W-1:0] f_a_b;
    logic         f_c0_b;
    logic         f_c15;
    logic [W-1:0] r_s;
    logic [W-1:0] r_a_b;
    logic         r_c0_b;
    logic         r_c15;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic         r_c0_f;
    logic         r_z;

    modport master (
        output dir, f_a, f_b, f_c0_f, f_z, r_s, r_a_b, r_c0_b, r_c15,
        input  f_s, f_a_b, f_c0_b, f_c15, r_a, r_b, r_c0_f, r_z
    );

    modport slave (
        input  dir, f_a, f_b, f_c0_f, f_z, r_s, r_a_b, r_c0_b, r_c15,
        output f_s, f_a_b, f_c0_b, f_c15, r_a, r_b, r_c0_f, r_z
    );
endinterface
`default_nettype wire

// File: rtl/fa16_rev_chk.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fa16_rev_chk                                                         |
// | Golden-sum and reverse-recovery comparators (purely combinational).  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fa16_rev_chk #(
    parameter int W = 16
) (
    input  logic [W-1:0] i_op_a,
    input  logic [W-1:0] i_op_b,
    input  logic         i_op_c0,
    input  logic         i_op_z,
    input  logic [W-1:0] i_fwd_s,
    input  logic         i_fwd_c15,
    input  logic [W-1:0] i_r_a,
    input  logic [W-1:0] i_r_b,
    input  logic         i_r_c0_f,
    input  logic         i_r_z,
    output logic         o_rev_mismatch,
    output logic         o_sum_mismatch
);
    logic [W:0] w_golden;

    assign w_golden = {1'b0, i_op_a} + {1'b0, i_op_b} + {{W{1'b0}}, i_op_c0};

    // A set ancilla changes what the core computes, so the sum is only judged with z clear.
    assign o_sum_mismatch = !i_op_z && (w_golden != {i_fwd_c15, i_fwd_s});

    assign o_rev_mismatch = ({i_r_a, i_r_b, i_r_c0_f, i_r_z} !=
                             {i_op_a, i_op_b, i_op_c0, i_op_z});
endmodule
`default_nettype wire

// File: rtl/fa16_rev_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fa16_rev_seq                                                         |
// | Runs forward then backward passes on fa16_rev and reports errors.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fa16_rev_seq
    import fa16_rev_seq_pkg::*;
#(
    parameter int W          = c_W,
    parameter int SETTLE_CYC = 2,
    parameter int ERRCNT_W   = 8
) (
    input  logic            clk,
    input  logic            rst,
    fa16_rev_seq_if.slave   host,
    fa16_rev_core_if.master core
);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(SETTLE_CYC - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                w_last;

    logic [W-1:0]        r_op_a;
    logic [W-1:0]        r_op_b;
    logic                r_op_c0;
    logic                r_op_z;
    logic [W-1:0]        r_cap_s;
    logic [W-1:0]        r_cap_a_b;
    logic                r_cap_c0_b;
    logic                r_cap_c15;
    logic                r_sum_mis;

    logic                r_dir;
    logic                r_req_ready;
    logic                r_rsp_valid;
    logic [W-1:0]        r_rsp_s;
    logic                r_rsp_c15;
    logic [1:0]          r_rsp_err;
    logic [ERRCNT_W-1:0] r_err_cnt;

    logic                w_rev_mis;
    logic                w_sum_mis;

    assign w_last = (r_cnt == c_LAST);

    fa16_rev_chk #(.W(W)) u_chk (
        .i_op_a         (r_op_a),
        .i_op_b         (r_op_b),
        .i_op_c0        (r_op_c0),
        .i_op_z         (r_op_z),
        .i_fwd_s        (core.f_s),
        .i_fwd_c15      (core.f_c15),
        .i_r_a          (core.r_a),
        .i_r_b          (core.r_b),
        .i_r_c0_f       (core.r_c0_f),
        .i_r_z          (core.r_z),
        .o_rev_mismatch (w_rev_mis),
        .o_sum_mismatch (w_sum_mis)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (host.req_valid) w_state_nxt = ST_FWD;
            ST_FWD:  if (w_last)         w_state_nxt = ST_REV;
            ST_REV:  if (w_last)         w_state_nxt = ST_RSP;
            ST_RSP:  if (host.rsp_ready) w_state_nxt = ST_IDLE;
            default:                     w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_op_c0     <= 1'b0;
            r_op_z      <= 1'b0;
            r_cap_s     <= '0;
            r_cap_a_b   <= '0;
            r_cap_c0_b  <= 1'b0;
            r_cap_c15   <= 1'b0;
            r_sum_mis   <= 1'b0;
            r_dir       <= 1'b0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_s     <= '0;
            r_rsp_c15   <= 1'b0;
            r_rsp_err   <= 2'b00;
            r_err_cnt   <= '0;
        end else begin
            r_req_ready <= (w_state_nxt == ST_IDLE);
            r_dir       <= (w_state_nxt == ST_REV);
            r_rsp_valid <= (w_state_nxt == ST_RSP);
            r_cnt       <= ((r_state == ST_FWD || r_state == ST_REV) && !w_last)
                           ? r_cnt + 1'b1 : '0;
            case (r_state)
                ST_IDLE: begin
                    if (host.req_valid) begin
                        r_op_a  <= host.req_a;
                        r_op_b  <= host.req_b;
                        r_op_c0 <= host.req_c0;
                        r_op_z  <= host.req_z;
                    end
                end
                ST_FWD: begin
                    if (w_last) begin
                        r_cap_s    <= core.f_s;
                        r_cap_a_b  <= core.f_a_b;
                        r_cap_c0_b <= core.f_c0_b;
                        r_cap_c15  <= core.f_c15;
                        r_sum_mis  <= w_sum_mis;
                    end
                end
                ST_REV: begin
                    if (w_last) begin
                        r_rsp_s              <= r_cap_s;
                        r_rsp_c15            <= r_cap_c15;
                        r_rsp_err[c_ERR_REV] <= w_rev_mis;
                        r_rsp_err[c_ERR_SUM] <= r_sum_mis;
                        r_cap_s              <= '0;
                        r_cap_a_b            <= '0;
                        r_cap_c0_b           <= 1'b0;
                        r_cap_c15            <= 1'b0;
                    end
                end
                ST_RSP: begin
                    if (host.rsp_ready && (r_rsp_err != 2'b00) && (r_err_cnt != '1))
                        r_err_cnt <= r_err_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign host.req_ready = r_req_ready;
    assign host.rsp_valid = r_rsp_valid;
    assign host.rsp_s     = r_rsp_s;
    assign host.rsp_c15   = r_rsp_c15;
    assign host.rsp_err   = r_rsp_err;
    assign host.err_cnt   = r_err_cnt;

    // The capture registers double as the backward drive; the wrapper tristates f_* by dir.
    assign core.dir    = r_dir;
    assign core.f_a    = r_op_a;
    assign core.f_b    = r_op_b;
    assign core.f_c0_f = r_op_c0;
    assign core.f_z    = r_op_z;
    assign core.r_s    = r_cap_s;
    assign core.r_a_b  = r_cap_a_b;
    assign core.r_c0_b = r_cap_c0_b;
    assign core.r_c15  = r_cap_c15;
endmodule
`default_nettype wire

// File: tb/tb_fa16_rev_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fa16_rev_seq                                                      |
// | Scoreboard bench for fa16_rev_seq with a fault-injectable core.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_fa16_rev_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fa16_rev_seq_if  #(.W(16), .ERRCNT_W(8)) hif ();
    fa16_rev_core_if #(.W(16))               cif ();

    fa16_rev_seq #(.W(16), .SETTLE_CYC(2), .ERRCNT_W(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .host (hif),
        .core (cif)
    );

    // Core model: A_B carries A, C0_b carries C0, Z passes through; faults are self-consistent.
    logic        flip_ra3 = 1'b0;
    logic        sum_off  = 1'b0;
    logic [16:0] m_sum;
    always_comb begin
        m_sum      = {1'b0, cif.f_a} + {1'b0, cif.f_b} + {16'd0, cif.f_c0_f};
        cif.f_s    = m_sum[15:0] + {15'd0, sum_off};
        cif.f_c15  = m_sum[16];
        cif.f_a_b  = cif.f_a;
        cif.f_c0_b = cif.f_c0_f;
        cif.r_a    = cif.r_a_b ^ (flip_ra3 ? 16'h0008 : 16'h0000);
        cif.r_b    = cif.r_s - {15'd0, sum_off} - cif.r_a_b - {15'd0, cif.r_c0_b};
        cif.r_c0_f = cif.r_c0_b;
        cif.r_z    = cif.f_z;
    end

    typedef struct packed {
        logic [15:0] s;
        logic        c15;
        logic [1:0]  err;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   exp_cnt = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic c0, input logic z);
        int          n;
        logic [16:0] g;
        exp_t        e;
        n = 0;
        while (hif.req_ready !== 1'b1 && n < 50) begin step(); n++; end
        hif.req_a = a; hif.req_b = b; hif.req_c0 = c0; hif.req_z = z;
        hif.req_valid = 1'b1;
        step();
        hif.req_valid = 1'b0;
        g     = {1'b0, a} + {1'b0, b} + {16'd0, c0};
        e.s   = g[15:0] + {15'd0, sum_off};
        e.c15 = g[16];
        e.err = {sum_off & ~z, flip_ra3};
        sb.push_back(e);
    endtask

    // k counts samples from the one just after the accept edge; dirs[k] records dir there.
    task automatic wait_rsp(output int k, output logic [7:0] dirs);
        k = 1;
        dirs = '0;
        while (hif.rsp_valid !== 1'b1 && k < 40) begin
            if (k < 8) dirs[k] = cif.dir;
            step();
            k++;
        end
    endtask

    task automatic ack(input logic [1:0] err);
        hif.rsp_ready = 1'b1;
        step();
        hif.rsp_ready = 1'b0;
        if (err != 2'b00 && exp_cnt < 255) exp_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        n_chk++; if ({hif.req_ready, hif.rsp_valid, cif.dir} !== 3'b100)
            $display("FAIL reset_ctl: got %b want 100", {hif.req_ready, hif.rsp_valid, cif.dir}); else n_pass++;
        n_chk++; if (hif.err_cnt !== 8'd0)
            $display("FAIL reset_err_cnt: got %0d want 0", hif.err_cnt); else n_pass++;
        n_chk++; if ({cif.r_s, cif.r_a_b, cif.r_c0_b, cif.r_c15, cif.f_a, cif.f_b} !== 66'd0)
            $display("FAIL reset_drives: got r_s=%h r_a_b=%h f_a=%h f_b=%h want 0", cif.r_s, cif.r_a_b, cif.f_a, cif.f_b); else n_pass++;
        n_chk++; if ({hif.rsp_s, hif.rsp_c15, hif.rsp_err} !== 19'd0)
            $display("FAIL reset_rsp: got s=%h c15=%b err=%b want 0", hif.rsp_s, hif.rsp_c15, hif.rsp_err); else n_pass++;
    endtask

    task automatic test_basic();
        int k; logic [7:0] d; exp_t e;
        send(16'h1234, 16'h0FED, 1'b0, 1'b0);
        wait_rsp(k, d);
        n_chk++; if (k !== 5) $display("FAIL basic_latency: got %0d want 5", k); else n_pass++;
        n_chk++; if (d[4:1] !== 4'b1100) $display("FAIL basic_dir_seq: got %b want 1100", d[4:1]); else n_pass++;
        e = sb.pop_front();
        n_chk++; if ({hif.rsp_s, hif.rsp_c15, hif.rsp_err} !== {e.s, e.c15, e.err} || e.s !== 16'h2221)
            $display("FAIL basic_rsp: got s=%h c15=%b err=%b want s=2221 c15=%b err=%b", hif.rsp_s, hif.rsp_c15, hif.rsp_err, e.c15, e.err); else n_pass++;
        ack(e.err);
    endtask

    task automatic test_carry();
        int k; logic [7:0] d; exp_t e;
        send(16'hFFFF, 16'h0001, 1'b1, 1'b0);
        step(); step();
        n_chk++; if ({cif.dir, cif.r_s, cif.r_c15, cif.r_a_b} !== {1'b1, 16'h0001, 1'b1, 16'hFFFF})
            $display("FAIL carry_rev_drive: got dir=%b r_s=%h r_c15=%b r_a_b=%h want 1 0001 1 FFFF", cif.dir, cif.r_s, cif.r_c15, cif.r_a_b); else n_pass++;
        wait_rsp(k, d);
        e = sb.pop_front();
        n_chk++; if (k >= 40 || {hif.rsp_s, hif.rsp_c15, hif.rsp_err} !== {16'h0001, 1'b1, 2'b00})
            $display("FAIL carry_rsp: got s=%h c15=%b err=%b want 0001 1 00", hif.rsp_s, hif.rsp_c15, hif.rsp_err); else n_pass++;
        ack(e.err);
        n_chk++; if ({cif.r_s, cif.r_c15} !== 17'd0)
            $display("FAIL carry_r_cleared: got r_s=%h r_c15=%b want 0", cif.r_s, cif.r_c15); else n_pass++;
    endtask

    task automatic test_faults();
        int k; logic [7:0] d; exp_t e;
        flip_ra3 = 1'b1;
        send(16'h0F0F, 16'h00F0, 1'b0, 1'b0);
        wait_rsp(k, d);
        e = sb.pop_front();
        n_chk++; if (k >= 40 || hif.rsp_err !== e.err || e.err !== 2'b01)
            $display("FAIL fault_rev_err: got %b want 01", hif.rsp_err); else n_pass++;
        ack(e.err);
        n_chk++; if (hif.err_cnt !== 8'(exp_cnt)) $display("FAIL fault_rev_cnt: got %0d want %0d", hif.err_cnt, exp_cnt); else n_pass++;
        flip_ra3 = 1'b0; sum_off = 1'b1;
        send(16'h0100, 16'h0020, 1'b0, 1'b0);
        wait_rsp(k, d);
        e = sb.pop_front();
        n_chk++; if (k >= 40 || {hif.rsp_s, hif.rsp_err} !== {16'h0121, 2'b10})
            $display("FAIL fault_sum_err: got s=%h err=%b want 0121 10", hif.rsp_s, hif.rsp_err); else n_pass++;
        ack(e.err);
        n_chk++; if (hif.err_cnt !== 8'(exp_cnt)) $display("FAIL fault_sum_cnt: got %0d want %0d", hif.err_cnt, exp_cnt); else n_pass++;
        send(16'h0100, 16'h0020, 1'b0, 1'b1);
        wait_rsp(k, d);
        e = sb.pop_front();
        n_chk++; if (k >= 40 || hif.rsp_err !== 2'b00)
            $display("FAIL fault_z_masks_sum: got %b want 00", hif.rsp_err); else n_pass++;
        ack(e.err);
        sum_off = 1'b0;
        n_chk++; if (hif.err_cnt !== 8'd2) $display("FAIL fault_z_cnt: got %0d want 2", hif.err_cnt); else n_pass++;
    endtask

    task automatic test_backpressure();
        int k; int bad; logic [7:0] d; exp_t e;
        send(16'hA5A5, 16'h1111, 1'b0, 1'b0);
        wait_rsp(k, d);
        e = sb.pop_front();
        bad = (k >= 40) ? 1 : 0;
        for (int i = 0; i < 10; i++) begin
            hif.req_valid = (i == 4);
            hif.req_a     = 16'hDEAD;
            step();
            if (hif.rsp_valid !== 1'b1 || hif.req_ready !== 1'b0 ||
                {hif.rsp_s, hif.rsp_c15, hif.rsp_err} !== {e.s, e.c15, e.err}) bad++;
        end
        hif.req_valid = 1'b0;
        n_chk++; if (bad != 0) $display("FAIL bp_stable: got %0d unstable cycles want 0", bad); else n_pass++;
        n_chk++; if (cif.f_a !== 16'hA5A5) $display("FAIL bp_not_latched: got f_a=%h want A5A5", cif.f_a); else n_pass++;
        ack(e.err);
        n_chk++; if ({hif.req_ready, hif.rsp_valid} !== 2'b10)
            $display("FAIL bp_release: got ready=%b valid=%b want 1 0", hif.req_ready, hif.rsp_valid); else n_pass++;
    endtask

    task automatic test_reset_abort();
        int k; int bad; logic [7:0] d; exp_t e;
        flip_ra3 = 1'b1;
        send(16'h3333, 16'h4444, 1'b1, 1'b0);
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        void'(sb.pop_back());
        exp_cnt = 0;
        flip_ra3 = 1'b0;
        n_chk++; if ({cif.dir, hif.req_ready, hif.rsp_valid, cif.r_s, cif.r_c15} !== {3'b010, 17'd0})
            $display("FAIL abort_state: got dir=%b ready=%b valid=%b r_s=%h want 0 1 0 0000", cif.dir, hif.req_ready, hif.rsp_valid, cif.r_s); else n_pass++;
        n_chk++; if (hif.err_cnt !== 8'd0) $display("FAIL abort_err_cnt: got %0d want 0", hif.err_cnt); else n_pass++;
        bad = 0;
        for (int i = 0; i < 6; i++) begin step(); if (hif.rsp_valid !== 1'b0) bad++; end
        n_chk++; if (bad != 0) $display("FAIL abort_no_rsp: got %0d valid cycles want 0", bad); else n_pass++;
        send(16'h7000, 16'h9001, 1'b0, 1'b0);
        wait_rsp(k, d);
        e = sb.pop_front();
        n_chk++; if (k !== 5 || {hif.rsp_s, hif.rsp_c15, hif.rsp_err} !== {16'h0001, 1'b1, 2'b00})
            $display("FAIL abort_recover: got k=%0d s=%h c15=%b err=%b want 5 0001 1 00", k, hif.rsp_s, hif.rsp_c15, hif.rsp_err); else n_pass++;
        ack(e.err);
    endtask

    task automatic test_back_to_back();
        int k; logic [7:0] d; exp_t e;
        for (int r = 0; r < 2; r++) begin
            send(16'h00FF + 16'(r), 16'h0100, 1'(r), 1'b0);
            n_chk++; if (hif.req_ready !== 1'b0 || cif.f_a !== 16'h00FF + 16'(r))
                $display("FAIL b2b_accept%0d: got ready=%b f_a=%h want 0 %h", r, hif.req_ready, cif.f_a, 16'h00FF + 16'(r)); else n_pass++;
            wait_rsp(k, d);
            e = sb.pop_front();
            n_chk++; if (k !== 5 || {hif.rsp_s, hif.rsp_c15, hif.rsp_err} !== {e.s, e.c15, e.err})
                $display("FAIL b2b_rsp%0d: got k=%0d s=%h err=%b want 5 %h %b", r, k, hif.rsp_s, hif.rsp_err, e.s, e.err); else n_pass++;
            ack(e.err);
        end
    endtask

    task automatic test_saturation();
        int k; int bad; logic [7:0] d; exp_t e;
        bad = 0;
        flip_ra3 = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(16'(i * 7), 16'(i), 1'b0, 1'b0);
            wait_rsp(k, d);
            e = sb.pop_front();
            if (k >= 40 || hif.rsp_err !== e.err) bad++;
            ack(e.err);
            if (hif.err_cnt !== 8'(exp_cnt)) bad++;
        end
        flip_ra3 = 1'b0;
        n_chk++; if (bad != 0) $display("FAIL sat_track: got %0d bad responses want 0", bad); else n_pass++;
        n_chk++; if (hif.err_cnt !== 8'hFF) $display("FAIL sat_final: got %h want FF", hif.err_cnt); else n_pass++;
    endtask

    initial begin
        hif.req_valid = 1'b0; hif.req_a = '0; hif.req_b = '0;
        hif.req_c0 = 1'b0; hif.req_z = 1'b0; hif.rsp_ready = 1'b0;
        test_reset();
        test_basic();
        test_carry();
        test_faults();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
